mem_rr_controller: RTL and testbench

//  Round-robin controller that shares the single-port memory (clk/addr/wr_en/rd_en/wdata/rdata)

---
 rtl/mem_ctrl_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/mem_rr_controller.sv | 96 +++++++++
 tb/tb_mem_rr_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the round-robin memory controller.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, CMD, WAIT_RD} ctrl_state_e;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr, wrapping.
// The pointer register lives in the caller.
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);
  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end
endmodule

// File: rtl/mem_rr_controller.sv
// Shares a single-port memory among NUM_REQ requesters, one op at a time (IDLE -> CMD -> [WAIT_RD] -> IDLE).
// Grants are round-robin in IDLE only; read data returns as a one-cycle pulse to the owning requester.
module mem_rr_controller
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_wr_en,
  output logic                          mem_rd_en,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  ctrl_state_e        state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   id;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [CNT_W-1:0]   cnt;
  logic               accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = (state == IDLE) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            id        <= gnt_idx;
            ptr       <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            mem_addr  <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata <= req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            mem_wr_en <= req_wr[gnt_idx];
            mem_rd_en <= !req_wr[gnt_idx];
            state     <= CMD;
          end
        end
        CMD: begin
          mem_wr_en <= 1'b0;
          mem_rd_en <= 1'b0;
          cnt       <= CNT_LOAD;
          state     <= mem_rd_en ? WAIT_RD : IDLE;
        end
        WAIT_RD: begin
          // Memory data is valid in the last wait cycle; register it with the owner's pulse.
          if (cnt == '0) begin
            rsp_rdata     <= mem_rdata;
            rsp_valid[id] <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_rr_controller.sv
// Scoreboarded bench: a cycle model of arbitration/timing predicts grants, commands and responses.
module tb_mem_rr_controller;
  localparam int N = 4, AW = 2, DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // DUT 1: RD_LATENCY = 1, scoreboarded
  logic [N-1:0]    req_valid = '0, req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata, mem_wdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_wr_en, mem_rd_en, busy;
  logic [DW-1:0]   mem_rdata = '0;

  mem_rr_controller #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  logic [DW-1:0] mem1 [N];
  always @(posedge clk) begin
    if (mem_wr_en) mem1[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem1[mem_addr];
  end

  // DUT 2: RD_LATENCY = 3, directed
  logic [N-1:0]    req_valid2 = '0, req_wr2 = '0;
  logic [N*AW-1:0] req_addr2 = '0;
  logic [N*DW-1:0] req_wdata2 = '0;
  logic [N-1:0]    req_ready2, rsp_valid2;
  logic [DW-1:0]   rsp_rdata2, mem_wdata2;
  logic [AW-1:0]   mem_addr2;
  logic            mem_wr_en2, mem_rd_en2, busy2;
  logic [DW-1:0]   p0 = '0, p1 = '0, p2 = '0;

  mem_rr_controller #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2), .req_wr(req_wr2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .mem_addr(mem_addr2), .mem_wr_en(mem_wr_en2), .mem_rd_en(mem_rd_en2), .mem_wdata(mem_wdata2),
    .mem_rdata(p2), .busy(busy2));

  logic [DW-1:0] mem2 [N];
  always @(posedge clk) begin
    if (mem_wr_en2) mem2[mem_addr2] <= mem_wdata2;
    p0 <= mem2[mem_addr2];
    p1 <= p0;
    p2 <= p1;
  end

  // Per-requester op lists for DUT 1
  typedef struct packed {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} op_t;
  op_t ops [N][16];
  int  n_ops [N] = '{0, 0, 0, 0};
  int  head  [N] = '{0, 0, 0, 0};
  logic [N-1:0] acc = '0;

  task automatic load(input int r, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ops[r][n_ops[r]] = '{wr, a, d};
    n_ops[r]++;
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) head[i]++;
      req_valid[i] = (head[i] < n_ops[i]);
      if (req_valid[i]) begin
        req_wr[i]            = ops[i][head[i]].wr;
        req_addr[i*AW +: AW]  = ops[i][head[i]].addr;
        req_wdata[i*DW +: DW] = ops[i][head[i]].data;
      end
    end
  end

  // Reference model and scoreboard
  typedef struct {int due; logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} cmd_t;
  typedef struct {int due; int id; logic [DW-1:0] data;} rsp_t;
  cmd_t cmdq[$];
  rsp_t rspq[$];
  int   glog[$], gcyc[$];
  logic [DW-1:0] ref_mem [N];
  int   m_busy = 0, m_ptr = 0;
  logic mon_en = 1'b0;
  logic [DW-1:0] last_rsp_dat = '0;
  int   last_rsp_cyc = 0, last_rsp_id = -1;

  always @(negedge clk) begin
    cmd_t c;
    rsp_t r;
    logic [N-1:0] er, ev;
    logic ewr, erd;
    int g, ii;
    if (!mon_en) begin
      acc = '0; m_busy = 0; m_ptr = 0;
      cmdq.delete(); rspq.delete();
    end else begin
      ewr = 1'b0; erd = 1'b0;
      if (cmdq.size() > 0 && cmdq[0].due == cyc) begin
        c = cmdq.pop_front();
        ewr = c.wr; erd = !c.wr;
        check("mem_addr", mem_addr, c.addr);
        check("mem_wdata", mem_wdata, c.data);
      end
      check("mem_wr_en", mem_wr_en, ewr);
      check("mem_rd_en", mem_rd_en, erd);
      ev = '0;
      if (rspq.size() > 0 && rspq[0].due == cyc) begin
        r = rspq.pop_front();
        ev[r.id] = 1'b1;
        check("rsp_rdata", rsp_rdata, r.data);
      end
      check("rsp_valid", rsp_valid, ev);
      if (|rsp_valid) begin
        last_rsp_dat = rsp_rdata; last_rsp_cyc = cyc;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) last_rsp_id = i;
      end
      check("busy", busy, m_busy != 0);
      er = '0;
      if (m_busy == 0)
        for (int off = 0; off < N; off++) begin
          ii = (m_ptr + off) % N;
          if (er == '0 && req_valid[ii]) er[ii] = 1'b1;
        end
      check("req_ready", req_ready, er);
      acc = req_valid & req_ready;
      if (m_busy > 0) m_busy--;
      else if (er != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (er[i]) g = i;
        m_ptr = (g + 1) % N;
        glog.push_back(g); gcyc.push_back(cyc);
        c.due = cyc + 1; c.wr = req_wr[g];
        c.addr = req_addr[g*AW +: AW]; c.data = req_wdata[g*DW +: DW];
        cmdq.push_back(c);
        if (c.wr) begin
          ref_mem[c.addr] = c.data; m_busy = 1;
        end else begin
          r.due = cyc + 3; r.id = g; r.data = ref_mem[c.addr];
          rspq.push_back(r); m_busy = 2;
        end
      end
    end
  end

  function automatic logic all_idle();
    for (int i = 0; i < N; i++) if (head[i] != n_ops[i]) return 1'b0;
    return (m_busy == 0) && (rspq.size() == 0) && (cmdq.size() == 0) && (req_valid == '0);
  endfunction

  task automatic drain(input string tag);
    int k = 0;
    do begin @(posedge clk); k++; end while (!all_idle() && k < 200);
    check({tag, "_drain"}, k < 200, 1'b1);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_grants(input string tag, input int exp_idx[$], input int gap);
    check({tag, "_count"}, glog.size(), exp_idx.size());
    for (int k = 0; k < exp_idx.size() && k < glog.size(); k++) begin
      check({tag, "_order"}, glog[k], exp_idx[k]);
      if (k > 0) check({tag, "_gap"}, gcyc[k] - gcyc[k-1], gap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, k;
    #2;
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wr_en", mem_wr_en, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_busy2", busy2, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;

    // Fill memory through req3 (leaves pointer at 0)
    load(3, 1, 0, 8'h11); load(3, 1, 1, 8'h22); load(3, 1, 2, 8'h33); load(3, 1, 3, 8'h44);
    drain("fill");

    // All four read: rotate 0,1,2,3 then 0, three cycles apart
    glog.delete(); gcyc.delete();
    load(0, 0, 0, 0); load(1, 0, 1, 0); load(2, 0, 2, 0); load(3, 0, 3, 0); load(0, 0, 3, 0);
    drain("t3");
    check_grants("t3", '{0, 1, 2, 3, 0}, 3);

    // Write then read back on req0
    glog.delete(); gcyc.delete();
    load(0, 1, 2, 8'hA5); load(0, 0, 2, 8'h00);
    drain("t2");
    check_grants("t2", '{0, 0}, 2);
    check("t2_rdata", last_rsp_dat, 8'hA5);
    check("t2_rsp_id", last_rsp_id, 0);
    if (gcyc.size() == 2) check("t2_rsp_lat", last_rsp_cyc - gcyc[1], 3);

    // Back-to-back writes from req1
    glog.delete(); gcyc.delete();
    for (int i = 0; i < 4; i++) load(1, 1, AW'(i), 8'(8'h50 + i));
    drain("t5");
    check_grants("t5", '{1, 1, 1, 1}, 2);

    // Reset during WAIT_RD of a req1 read (pointer moves to 2 before reset)
    glog.delete(); gcyc.delete();
    load(1, 0, 1, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (glog.size() == 0 && k < 50);
    check("t1_accept", glog.size(), 1);
    a = (gcyc.size() > 0) ? gcyc[0] : cyc;
    while (cyc < a + 2) @(negedge clk);
    #1; mon_en = 1'b0; reset = 1'b0;
    #1;
    check("t1_busy", busy, 0);
    check("t1_rsp_valid", rsp_valid, 0);
    check("t1_rsp_rdata", rsp_rdata, 0);
    check("t1_mem_rd_en", mem_rd_en, 0);
    check("t1_mem_addr", mem_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t1_post_rsp", rsp_valid, 0);
      check("t1_post_busy", busy, 0);
    end

    // req0/req2 contend right after reset: pointer restarted at 0
    glog.delete(); gcyc.delete();
    for (int i = 0; i < 3; i++) begin
      load(0, 1, 0, 8'(8'hC0 + i));
      load(2, 1, 3, 8'(8'hD0 + i));
    end
    drain("t4");
    check_grants("t4", '{0, 2, 0, 2, 0, 2}, 2);

    // RD_LATENCY = 3 instance: write 3C to addr 1, then read it back
    @(posedge clk); #1;
    req_wr2 = 4'b0001; req_addr2 = 8'h01; req_wdata2 = 32'h3C; req_valid2 = 4'b0001;
    k = 0;
    do begin @(negedge clk); k++; end while (req_ready2 != 4'b0001 && k < 20);
    check("t6_wr_accept", req_ready2, 4'b0001);
    @(posedge clk); #1 req_valid2 = '0;
    repeat (3) @(posedge clk);
    #1 req_wr2 = '0; req_valid2 = 4'b0001;
    k = 0;
    do begin @(negedge clk); k++; end while (req_ready2 != 4'b0001 && k < 20);
    check("t6_rd_accept", req_ready2, 4'b0001);
    @(posedge clk); #1 req_valid2 = '0;
    for (int s = 1; s <= 6; s++) begin
      @(negedge clk);
      check("t6_rd_en", mem_rd_en2, s == 1);
      check("t6_wr_en", mem_wr_en2, 0);
      check("t6_busy", busy2, s <= 4);
      check("t6_rsp_valid", rsp_valid2, (s == 5) ? 4'b0001 : 4'b0000);
      if (s == 5) check("t6_rdata", rsp_rdata2, 8'h3C);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
